// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - serialised command sequencer feeding an ALU from an 8x16 register file
module alu_issue_sequencer #(
  parameter int ALU_LAT = 1,
  parameter int NREG    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_operation,
  input  logic [31:0] alu_Result,
  input  logic [15:0] alu_Remainder,
  input  logic        alu_Z,
  input  logic        alu_N,
  input  logic        alu_C,
  input  logic        alu_V,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd15;
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WB1,
    S_WB2,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   regs [NREG];
  logic [3:0]    op_q;
  logic [2:0]    rd_q;
  logic [15:0]   imm_q;
  logic [31:0]   res_q;
  logic [15:0]   rem_q;
  logic [3:0]    flag_q;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          op_is_alu;
  logic          op_is_undef;
  logic          op_is_wide;

  assign cnt_last    = (cnt == CW'(ALU_LAT - 1));
  assign op_is_alu   = (op_q < 4'd12);
  assign op_is_undef = (op_q >= 4'd12) && (op_q != OP_LDI);
  assign op_is_wide  = (op_q == OP_MUL) || (op_q == OP_DIV);

  // The flag register is the response flag source: ALU ops overwrite it, other ops leave it as is.
  assign rsp_flags = flag_q;
  assign dbg_data  = regs[dbg_addr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_last) state_nxt = S_WB1;
      end
      S_WB1: begin
        state_nxt = op_is_wide ? S_WB2 : S_RESP;
      end
      S_WB2: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand fetch, ALU capture, register writeback and response payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 16'h0000;
      op_q          <= 4'd0;
      rd_q          <= 3'd0;
      imm_q         <= 16'h0000;
      res_q         <= 32'h0;
      rem_q         <= 16'h0000;
      flag_q        <= 4'd0;
      cnt           <= '0;
      alu_A         <= 16'h0000;
      alu_B         <= 16'h0000;
      alu_operation <= 4'd0;
      rsp_data      <= 16'h0000;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q          <= cmd_op;
            rd_q          <= cmd_rd;
            imm_q         <= cmd_imm;
            alu_A         <= regs[cmd_rs1];
            alu_B         <= regs[cmd_rs2];
            alu_operation <= (cmd_op < 4'd12) ? cmd_op : 4'd0;
            cnt           <= '0;
          end
        end
        S_ISSUE: begin
          if (cnt_last) begin
            res_q <= alu_Result;
            rem_q <= alu_Remainder;
            if (op_is_alu) flag_q <= {alu_Z, alu_N, alu_C, alu_V};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB1: begin
          rsp_err <= op_is_undef;
          if (op_is_alu) begin
            regs[rd_q] <= res_q[15:0];
            rsp_data   <= res_q[15:0];
          end else if (op_q == OP_LDI) begin
            regs[rd_q] <= imm_q;
            rsp_data   <= imm_q;
          end else begin
            rsp_data   <= 16'h0000;
          end
        end
        S_WB2: begin
          // 3-bit index wraps naturally, so rd=7 lands in r0.
          if (op_q == OP_MUL) regs[rd_q + 3'd1] <= res_q[31:16];
          else                regs[rd_q + 3'd1] <= rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - randomized self-checking bench for alu_issue_sequencer
module tb_alu_issue_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Main instance (ALU_LAT=1)
  logic        rst, cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm, alu_A, alu_B, alu_Remainder;
  logic [3:0]  alu_operation;
  logic [31:0] alu_Result;
  logic        alu_Z, alu_N, alu_C, alu_V;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  // Second instance (ALU_LAT=4) for the reset-abandon case
  logic        q_rst, q_cmd_valid, q_cmd_ready;
  logic [3:0]  q_cmd_op;
  logic [2:0]  q_cmd_rd, q_cmd_rs1, q_cmd_rs2;
  logic [15:0] q_cmd_imm, q_alu_A, q_alu_B, q_alu_Remainder;
  logic [3:0]  q_alu_operation;
  logic [31:0] q_alu_Result;
  logic        q_alu_Z, q_alu_N, q_alu_C, q_alu_V;
  logic        q_rsp_valid, q_rsp_ready, q_rsp_err;
  logic [15:0] q_rsp_data;
  logic [3:0]  q_rsp_flags;
  logic [2:0]  q_dbg_addr;
  logic [15:0] q_dbg_data;

  // Reference model state
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;
  logic [15:0] last_data;
  logic [3:0]  last_flags;
  logic        last_err;

  // Behavioural ALU stub: returns {Result[31:0], Remainder[15:0], Z, N, C, V}
  function automatic logic [51:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic signed [31:0] p;
    logic signed [15:0] qt, rm;
    logic [31:0] res;
    logic [15:0] rem;
    logic c, v;
    c = 1'b0; v = 1'b0; rem = 16'h0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
        res = {{16{r[15]}}, r};
      end
      4'd1: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
        res = {{16{r[15]}}, r};
      end
      4'd2: begin
        p = $signed(a) * $signed(b);
        res = p;
      end
      4'd3: begin
        if (b == 16'h0) begin
          res = 32'h0; rem = a; v = 1'b1;
        end else begin
          qt = $signed(a) / $signed(b);
          rm = $signed(a) % $signed(b);
          res = {{16{qt[15]}}, qt}; rem = rm;
        end
      end
      default: res = {16'h0, a ^ (b + {12'h0, op})};
    endcase
    return {res, rem, (res[15:0] == 16'h0), res[15], c, v};
  endfunction

  assign {alu_Result, alu_Remainder, alu_Z, alu_N, alu_C, alu_V} = alu_f(alu_operation, alu_A, alu_B);
  assign {q_alu_Result, q_alu_Remainder, q_alu_Z, q_alu_N, q_alu_C, q_alu_V} = alu_f(q_alu_operation, q_alu_A, q_alu_B);

  alu_issue_sequencer #(.ALU_LAT(1), .NREG(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_operation(alu_operation), .alu_Result(alu_Result),
    .alu_Remainder(alu_Remainder), .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_sequencer #(.ALU_LAT(4), .NREG(8)) u_dut4 (
    .clk(clk), .rst(q_rst), .cmd_valid(q_cmd_valid), .cmd_ready(q_cmd_ready), .cmd_op(q_cmd_op),
    .cmd_rd(q_cmd_rd), .cmd_rs1(q_cmd_rs1), .cmd_rs2(q_cmd_rs2), .cmd_imm(q_cmd_imm),
    .alu_A(q_alu_A), .alu_B(q_alu_B), .alu_operation(q_alu_operation), .alu_Result(q_alu_Result),
    .alu_Remainder(q_alu_Remainder), .alu_Z(q_alu_Z), .alu_N(q_alu_N), .alu_C(q_alu_C), .alu_V(q_alu_V),
    .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_data(q_rsp_data), .rsp_flags(q_rsp_flags),
    .rsp_err(q_rsp_err), .dbg_addr(q_dbg_addr), .dbg_data(q_dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm, input int hold);
    logic [51:0] a;
    logic [15:0] e_data;
    logic [3:0]  e_flags;
    logic        e_err;
    int          e_lat, cyc;
    a       = alu_f(op, m_regs[rs1], m_regs[rs2]);
    e_err   = (op >= 4'd12) && (op <= 4'd14);
    e_lat   = (op == 4'd2 || op == 4'd3) ? 4 : 3;
    e_flags = (op < 4'd12) ? a[3:0] : m_flags;
    e_data  = (op < 4'd12) ? a[35:20] : ((op == 4'd15) ? imm : 16'h0);

    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_valid = 1'b1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 30) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk($sformatf("latency_op%0d", op), 32'(cyc), 32'(e_lat));
    chk("rsp_data", 32'(rsp_data), 32'(e_data));
    chk("rsp_flags", 32'(rsp_flags), 32'(e_flags));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    last_data = rsp_data; last_flags = rsp_flags; last_err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(e_data));
      chk("hold_flags", 32'(rsp_flags), 32'(e_flags));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);

    if (op < 4'd12) begin
      m_regs[rd] = a[35:20];
      if (op == 4'd2) m_regs[3'(rd + 3'd1)] = a[51:36];
      if (op == 4'd3) m_regs[3'(rd + 3'd1)] = a[19:4];
      m_flags = a[3:0];
    end else if (op == 4'd15) begin
      m_regs[rd] = imm;
    end
    check_regs("wb");
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [3:0] rop;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    cmd_imm = 16'h0; rsp_ready = 1'b0; dbg_addr = 3'd0;
    q_rst = 1'b1; q_cmd_valid = 1'b0; q_cmd_op = 4'd0; q_cmd_rd = 3'd0; q_cmd_rs1 = 3'd0;
    q_cmd_rs2 = 3'd0; q_cmd_imm = 16'h0; q_rsp_ready = 1'b1; q_dbg_addr = 3'd2;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_flags = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; q_rst = 1'b0;

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_alu_A", 32'(alu_A), 32'd0);
    chk("rst_alu_B", 32'(alu_B), 32'd0);
    chk("rst_alu_op", 32'(alu_operation), 32'd0);
    check_regs("rst");

    // Signed overflow on ADD
    run_cmd(4'd15, 3'd1, 3'd0, 3'd0, 16'h7FFF, 0);
    run_cmd(4'd15, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
    run_cmd(4'd0, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("tp_add_data", 32'(last_data), 32'h8000);
    chk("tp_add_flags", 32'(last_flags), 32'b0101);
    chk("tp_add_err", 32'(last_err), 32'd0);
    // MUL with destination wrap
    run_cmd(4'd15, 3'd5, 3'd0, 3'd0, 16'h0100, 0);
    run_cmd(4'd2, 3'd7, 3'd5, 3'd5, 16'h0, 1);
    chk("tp_mul_data", 32'(last_data), 32'h0000);
    dbg_addr = 3'd0; #1 chk("tp_mul_r0", 32'(dbg_data), 32'h0001);
    // Signed DIV quotient and remainder
    run_cmd(4'd15, 3'd4, 3'd0, 3'd0, 16'hFFF9, 0);
    run_cmd(4'd15, 3'd6, 3'd0, 3'd0, 16'h0002, 0);
    run_cmd(4'd3, 3'd2, 3'd4, 3'd6, 16'h0, 0);
    chk("tp_div_data", 32'(last_data), 32'hFFFD);
    dbg_addr = 3'd3; #1 chk("tp_div_r3", 32'(dbg_data), 32'hFFFF);
    // Backpressure
    run_cmd(4'd0, 3'd0, 3'd1, 3'd2, 16'h0, 5);
    // Undefined opcode
    run_cmd(4'd13, 3'd4, 3'd1, 3'd2, 16'hAAAA, 0);
    chk("tp_undef_err", 32'(last_err), 32'd1);
    chk("tp_undef_data", 32'(last_data), 32'd0);

    // Random command stream
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      run_cmd(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              16'($urandom), int'($urandom_range(0, 3)));
    end

    // ALU_LAT=4 instance: load a register, then reset mid-ISSUE of a SUB
    @(negedge clk);
    q_cmd_op = 4'd15; q_cmd_rd = 3'd2; q_cmd_imm = 16'h1234; q_cmd_valid = 1'b1;
    @(posedge clk);
    #1 q_cmd_valid = 1'b0;
    cyc = 1;
    while (!q_rsp_valid && cyc < 30) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("q_latency", 32'(cyc), 32'd6);
    @(posedge clk);
    #1;
    chk("q_ready_after", 32'(q_cmd_ready), 32'd1);
    chk("q_r2_loaded", 32'(q_dbg_data), 32'h1234);
    @(negedge clk);
    q_cmd_op = 4'd1; q_cmd_rd = 3'd1; q_cmd_rs1 = 3'd2; q_cmd_rs2 = 3'd2; q_cmd_valid = 1'b1;
    @(posedge clk);
    #1 q_cmd_valid = 1'b0;
    chk("q_issue_A", 32'(q_alu_A), 32'h1234);
    @(posedge clk);
    #1 q_rst = 1'b1;
    @(posedge clk);
    #1 q_rst = 1'b0;
    chk("q_rst_valid", 32'(q_rsp_valid), 32'd0);
    chk("q_rst_A", 32'(q_alu_A), 32'd0);
    chk("q_rst_B", 32'(q_alu_B), 32'd0);
    chk("q_rst_ready", 32'(q_cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      q_dbg_addr = 3'(i);
      #1 chk($sformatf("q_rst_r%0d", i), 32'(q_dbg_data), 32'd0);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 if (q_rsp_valid) seen = 1'b1;
    end
    chk("q_no_rsp", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Upstream command stage for enhanced_ALU.
- Accepts register-based commands over a valid/ready handshake and reads operands from an 8x16 register file.
- Drives the ALU operand and opcode inputs, captures the result, remainder and flags, then writes results back to the register file.
- Returns a response over a second valid/ready handshake. Fully serialised: one command in flight at a time.

Parameters:
- ALU_LAT, 1, cycles from driving ALU inputs to capturing ALU outputs; minimum 1; 1 suits a combinational ALU.
- NREG, 8, register file depth; fixed at 8, indices are 3 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  4  opcode: 0-11 are ALU encodings; 15 = LOAD_IMM; 12-14 are undefined.
- cmd_rd  in  3  destination register.
- cmd_rs1  in  3  source register for ALU input A.
- cmd_rs2  in  3  source register for ALU input B.
- cmd_imm  in  16  immediate, used only by LOAD_IMM.
- alu_A  out  16  signed operand A to the ALU.
- alu_B  out  16  signed operand B to the ALU.
- alu_operation  out  4  opcode to the ALU.
- alu_Result  in  32  ALU result.
- alu_Remainder  in  16  ALU remainder.
- alu_Z, alu_N, alu_C, alu_V  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  16  primary result.
- rsp_flags  out  4  {Z,N,C,V}.
- rsp_err  out  1  undefined opcode.
- dbg_addr  in  3  register-file debug read index.
- dbg_data  out  16  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (rst=1 at an edge):
  - FSM goes to IDLE; all 8 registers clear to 0; the flag register clears to 0.
  - alu_A, alu_B and alu_operation go to 0; rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0.
  - A command in flight is abandoned with no writeback and no response.
  - cmd_ready=1 in the first cycle after reset deasserts.
- FSM states: IDLE, ISSUE, WB1, WB2, RESP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, latch op, rd and imm; latch regfile[rs1] into alu_A and regfile[rs2] into alu_B.
  - alu_operation = op for ALU opcodes, 0 otherwise. Go to ISSUE.
- ISSUE:
  - alu_A, alu_B and alu_operation are held stable. A counter runs ALU_LAT cycles.
  - On the last edge, capture alu_Result, alu_Remainder and {Z,N,C,V}, then go to WB1.
  - LOAD_IMM and undefined opcodes still spend ALU_LAT cycles here; their captured ALU values are discarded.
- WB1 (1 cycle), write rules by opcode:
  - ALU op: regfile[rd] <= Result[15:0].
  - LOAD_IMM: regfile[rd] <= imm.
  - Undefined opcode: no write.
  - Next state is WB2 for MUL (2) and DIV (3); RESP otherwise.
- WB2 (1 cycle):
  - MUL: regfile[(rd+1) mod 8] <= Result[31:16].
  - DIV: regfile[(rd+1) mod 8] <= Remainder.
  - Index wraps, so rd=7 writes r0. Next state is RESP.
- RESP:
  - rsp_valid=1 with data stable until the edge where rsp_ready=1; then rsp_valid=0 and go to IDLE.
  - rsp_data: Result[15:0] for ALU ops (quotient for DIV); imm for LOAD_IMM; 0 for undefined opcodes.
  - rsp_flags: the captured flags for ALU ops; for LOAD_IMM and undefined opcodes, the flag register's previous value, left unchanged.
  - rsp_err=1 only for opcodes 12-14.
- cmd_ready=0 in every state except IDLE.
- Latency: with ALU_LAT=1 and the command accepted at edge 0, rsp_valid rises in cycle 3 (cycle 4 for MUL/DIV); in general 2+ALU_LAT cycles (3+ALU_LAT for MUL/DIV).
- Hazards: operands are read only at acceptance, and all prior writes have completed by then. A command with rs==rd of the previous command sees the new value.
- dbg_data reflects a write on the cycle after the write edge.

Test Plan:
- LOAD_IMM r1=0x7FFF, LOAD_IMM r2=0x0001, ADD rd=3 rs1=1 rs2=2 -> rsp_data=0x8000, rsp_flags=4'b0101, r3=0x8000, rsp_err=0; rsp_valid first seen 3 cycles after the ADD handshake.
- LOAD r5=0x0100; MUL rd=7 rs1=5 rs2=5 -> rsp_data=0x0000, dbg r7=0x0000, r0=0x0001 (wrap); response 4 cycles after acceptance.
- LOAD r4=0xFFF9 (-7), r6=0x0002; DIV rd=2 rs1=4 rs2=6 -> rsp_data=0xFFFD, r2=0xFFFD, r3=0xFFFF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_flags stay constant and cmd_ready=0 throughout; IDLE with cmd_ready=1 one cycle after the rsp_ready=1 edge.
- cmd_op=13 -> rsp_err=1, rsp_data=0, rsp_flags equal to the previous value, all registers unchanged.
- ALU_LAT=4: assert rst during the second ISSUE cycle of SUB rd=1 -> next cycle rsp_valid=0, alu_A=alu_B=0, all registers 0, no response ever issued, cmd_ready=1 after rst drops.
